// File: rtl/tx_uart.sv
// Drains a first-word-fall-through TX FIFO into 8N1/8N2 async frames (start, 8 data LSB first, stop), one pop per frame, all outputs registered.
// Optional parity stage between data and stop is compiled in by defining TX_UART_PARITY_EN.
module tx_uart #(
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rdata,
    input  logic       rempty,
    output logic       rinc,
    output logic       tx,
    output logic       busy
);

`ifdef TX_UART_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [2:0]  STOP_LAST = 3'(STOP_BITS - 1);

    generate
        if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535 || STOP_BITS < 1 || STOP_BITS > 2 ||
            PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_cfg
            $error("tx_uart: illegal parameter combination");
        end
    endgenerate

    state_t      state, state_nxt;
    logic [7:0]  shreg, shreg_nxt;
    logic [15:0] baud, baud_nxt;
    logic [2:0]  bitcnt, bitcnt_nxt;
    logic        tx_nxt, rinc_nxt, busy_nxt;
    logic        bit_end;
`ifdef TX_UART_PARITY_EN
    logic        par, par_nxt;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            shreg  <= 8'h00;
            baud   <= 16'h0000;
            bitcnt <= 3'd0;
            tx     <= 1'b1;
            rinc   <= 1'b0;
            busy   <= 1'b0;
`ifdef TX_UART_PARITY_EN
            par    <= 1'b0;
`endif
        end else begin
            state  <= state_nxt;
            shreg  <= shreg_nxt;
            baud   <= baud_nxt;
            bitcnt <= bitcnt_nxt;
            tx     <= tx_nxt;
            rinc   <= rinc_nxt;
            busy   <= busy_nxt;
`ifdef TX_UART_PARITY_EN
            par    <= par_nxt;
`endif
        end
    end

    assign bit_end = (baud == BAUD_LAST);

    always_comb begin
        state_nxt  = state;
        shreg_nxt  = shreg;
        baud_nxt   = bit_end ? 16'h0000 : baud + 16'h0001;
        bitcnt_nxt = bitcnt;
        tx_nxt     = tx;
        rinc_nxt   = 1'b0;
        busy_nxt   = busy;
`ifdef TX_UART_PARITY_EN
        par_nxt    = par;
`endif
        case (state)
            IDLE: begin
                baud_nxt   = 16'h0000;
                bitcnt_nxt = 3'd0;
                tx_nxt     = 1'b1;
                busy_nxt   = 1'b0;
                // The pop edge itself drives the start bit, so tx drops one cycle after the FIFO is seen non-empty.
                if (!rempty) begin
                    shreg_nxt = rdata;
                    rinc_nxt  = 1'b1;
                    tx_nxt    = 1'b0;
                    busy_nxt  = 1'b1;
                    state_nxt = START;
`ifdef TX_UART_PARITY_EN
                    par_nxt   = (^rdata) ^ PARITY_ODD[0];
`endif
                end
            end
            START: begin
                if (bit_end) begin
                    state_nxt = DATA;
                    tx_nxt    = shreg[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    shreg_nxt = shreg >> 1;
                    if (bitcnt == 3'd7) begin
                        bitcnt_nxt = 3'd0;
`ifdef TX_UART_PARITY_EN
                        state_nxt  = PARITY;
                        tx_nxt     = par;
`else
                        state_nxt  = STOP;
                        tx_nxt     = 1'b1;
`endif
                    end else begin
                        bitcnt_nxt = bitcnt + 3'd1;
                        tx_nxt     = shreg[1];
                    end
                end
            end
`ifdef TX_UART_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_nxt = STOP;
                    tx_nxt    = 1'b1;
                end
            end
`endif
            STOP: begin
                // bitcnt is reused to count stop bits.
                if (bit_end) begin
                    if (bitcnt == STOP_LAST) begin
                        state_nxt  = IDLE;
                        busy_nxt   = 1'b0;
                        bitcnt_nxt = 3'd0;
                    end else begin
                        bitcnt_nxt = bitcnt + 3'd1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                tx_nxt    = 1'b1;
                busy_nxt  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_tx_uart.sv
// Bench for tx_uart: two instances (4 clk/bit 1 stop even parity; 3 clk/bit 2 stop odd parity) fed from queue-modelled FIFOs.
module tb_tx_uart;

`ifdef TX_UART_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] rdata0, rdata1;
    logic       rempty0, rempty1;
    logic       rinc0, tx0, busy0, rinc1, tx1, busy1;

    int total  = 0;
    int passed = 0;
    int cyc    = 0;
    int pops0  = 0;
    int pops1  = 0;
    int bad_pop = 0;
    logic [7:0] q0[$];
    logic [7:0] q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    tx_uart #(.CLKS_PER_BIT(4), .STOP_BITS(1), .PARITY_ODD(0)) u0 (
        .clk(clk), .rst_n(rst_n), .rdata(rdata0), .rempty(rempty0),
        .rinc(rinc0), .tx(tx0), .busy(busy0));

    tx_uart #(.CLKS_PER_BIT(3), .STOP_BITS(2), .PARITY_ODD(1)) u1 (
        .clk(clk), .rst_n(rst_n), .rdata(rdata1), .rempty(rempty1),
        .rinc(rinc1), .tx(tx1), .busy(busy1));

    // FIFO models: a registered rinc is high for one whole cycle, so each negedge sees it once.
    initial begin
        rempty0 = 1'b1;
        rdata0  = 8'h00;
        forever begin
            @(negedge clk);
            if (rinc0 === 1'b1) begin
                if (q0.size() > 0) void'(q0.pop_front());
                else bad_pop++;
                pops0++;
            end
            rempty0 = (q0.size() == 0);
            rdata0  = (q0.size() > 0) ? q0[0] : 8'h00;
        end
    end

    initial begin
        rempty1 = 1'b1;
        rdata1  = 8'h00;
        forever begin
            @(negedge clk);
            if (rinc1 === 1'b1) begin
                if (q1.size() > 0) void'(q1.pop_front());
                else bad_pop++;
                pops1++;
            end
            rempty1 = (q1.size() == 0);
            rdata1  = (q1.size() > 0) ? q1[0] : 8'h00;
        end
    end

    function automatic int cpb(input int i);
        return (i == 0) ? 4 : 3;
    endfunction

    function automatic int stops(input int i);
        return (i == 0) ? 1 : 2;
    endfunction

    function automatic int nbits(input int i);
        return 10 + stops(i) - 1 + PAR;
    endfunction

    function automatic logic get_tx(input int i);
        return (i == 0) ? tx0 : tx1;
    endfunction

    function automatic logic get_rinc(input int i);
        return (i == 0) ? rinc0 : rinc1;
    endfunction

    function automatic logic get_busy(input int i);
        return (i == 0) ? busy0 : busy1;
    endfunction

    // Reference frame: bit slot 0 start, slots 1..8 data LSB first, optional parity slot, then mark.
    function automatic logic exp_bit(input int i, input logic [7:0] d, input int slot);
        logic podd;
        podd = (i == 0) ? 1'b0 : 1'b1;
        if (slot == 0) return 1'b0;
        if (slot <= 8) return d[slot-1];
        if (PAR == 1 && slot == 9) return (^d) ^ podd;
        return 1'b1;
    endfunction

    task automatic check_frame(input int i, input logic [7:0] d, input string name, output int start_cyc);
        int waitn = 0;
        int bad   = 0;
        int nc;
        do begin
            @(negedge clk);
            waitn++;
        end while (get_rinc(i) !== 1'b1 && waitn < 300);
        total++;
        if (get_rinc(i) !== 1'b1) begin
            $display("FAIL %s_pop: rinc seen=%b required=1 within 300 clks", name, get_rinc(i));
            start_cyc = -1;
            return;
        end
        passed++;
        start_cyc = cyc;
        nc = nbits(i) * cpb(i);
        for (int k = 0; k < nc; k++) begin
            if (k > 0) @(negedge clk);
            if (get_tx(i) !== exp_bit(i, d, k / cpb(i))) bad++;
            if (get_busy(i) !== 1'b1) bad++;
            if (get_rinc(i) !== (k == 0)) bad++;
        end
        total++;
        if (bad != 0) $display("FAIL %s_frame: byte %h had %0d bad samples, required 0", name, d, bad);
        else passed++;
        @(negedge clk);
        total++;
        if (get_tx(i) !== 1'b1 || get_busy(i) !== 1'b0)
            $display("FAIL %s_gap: tx=%b busy=%b required tx=1 busy=0", name, get_tx(i), get_busy(i));
        else passed++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if (tx0 !== 1'b1) $display("FAIL reset_tx0: got %b required 1", tx0); else passed++;
        total++;
        if (rinc0 !== 1'b0) $display("FAIL reset_rinc0: got %b required 0", rinc0); else passed++;
        total++;
        if (busy0 !== 1'b0) $display("FAIL reset_busy0: got %b required 0", busy0); else passed++;
        total++;
        if ({tx1, rinc1, busy1} !== 3'b100)
            $display("FAIL reset_u1: tx/rinc/busy=%b required 100", {tx1, rinc1, busy1});
        else passed++;
        rst_n = 1'b1;
    endtask

    task automatic test_idle_empty();
        int bad = 0;
        repeat (100) begin
            @(negedge clk);
            if ({tx0, rinc0, busy0} !== 3'b100) bad++;
            if ({tx1, rinc1, busy1} !== 3'b100) bad++;
        end
        total++;
        if (bad != 0) $display("FAIL idle_empty: %0d bad samples, required 0", bad); else passed++;
        total++;
        if (pops0 + pops1 != 0) $display("FAIL idle_pops: got %0d required 0", pops0 + pops1); else passed++;
    endtask

    task automatic test_single_a5();
        int s;
        q0.push_back(8'hA5);
        check_frame(0, 8'hA5, "a5", s);
        total++;
        if (pops0 != 1) $display("FAIL a5_pops: got %0d required 1", pops0); else passed++;
        total++;
        if (rempty0 !== 1'b1) $display("FAIL a5_empty: got %b required 1", rempty0); else passed++;
    endtask

    task automatic test_back_to_back(input int i, input string name, input int n, input logic rnd);
        logic [7:0] b[$];
        int s[$];
        int st, p0, bad_period;
        logic [7:0] v;
        p0 = (i == 0) ? pops0 : pops1;
        for (int k = 0; k < n; k++) begin
            if (rnd) v = 8'($urandom);
            else if (i == 1) v = 8'h00;
            else v = (k == 0) ? 8'h02 : ((k == 1) ? 8'h12 : 8'h34);
            b.push_back(v);
            if (i == 0) q0.push_back(v); else q1.push_back(v);
        end
        for (int k = 0; k < n; k++) begin
            check_frame(i, b[k], name, st);
            s.push_back(st);
        end
        bad_period = 0;
        for (int k = 1; k < n; k++)
            if (s[k] - s[k-1] != nbits(i) * cpb(i) + 1) bad_period++;
        total++;
        if (bad_period != 0)
            $display("FAIL %s_period: %0d gaps differ from %0d clks", name, bad_period, nbits(i) * cpb(i) + 1);
        else passed++;
        total++;
        if (((i == 0) ? pops0 : pops1) - p0 != n)
            $display("FAIL %s_pops: got %0d required %0d", name, ((i == 0) ? pops0 : pops1) - p0, n);
        else passed++;
    endtask

    task automatic test_mid_reset();
        int waitn = 0;
        int bad = 0;
        int p0;
        p0 = pops0;
        q0.push_back(8'hFF);
        do begin
            @(negedge clk);
            waitn++;
        end while (rinc0 !== 1'b1 && waitn < 300);
        repeat (14) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        total++;
        if ({tx0, busy0, rinc0} !== 3'b100)
            $display("FAIL midrst_abort: tx/busy/rinc=%b required 100", {tx0, busy0, rinc0});
        else passed++;
        rst_n = 1'b1;
        repeat (60) begin
            @(negedge clk);
            if ({tx0, busy0, rinc0} !== 3'b100) bad++;
        end
        total++;
        if (bad != 0) $display("FAIL midrst_quiet: %0d bad samples, required 0", bad); else passed++;
        total++;
        if (pops0 - p0 != 1) $display("FAIL midrst_pops: got %0d required 1", pops0 - p0); else passed++;
    endtask

    task automatic test_parity();
        int s;
        q0.push_back(8'h07);
        check_frame(0, 8'h07, "par_even", s);
        q1.push_back(8'h07);
        check_frame(1, 8'h07, "par_odd", s);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1;
        test_reset();
        test_idle_empty();
        test_single_a5();
        test_back_to_back(0, "triplet", 3, 1'b0);
        test_back_to_back(1, "stop2", 2, 1'b0);
        test_back_to_back(0, "rand0", 6, 1'b1);
        test_back_to_back(1, "rand1", 4, 1'b1);
        test_mid_reset();
        test_parity();
        total++;
        if (bad_pop != 0) $display("FAIL pop_when_empty: got %0d required 0", bad_pop); else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/tx_uart.md
Name: tx_uart

Overview:
- Downstream neighbour of the 4-input TX serializer mux: drains the byte-wide TX FIFO that the mux writes (header, MSB, LSB) and shifts each byte out as an asynchronous serial frame on the host link.
- Connects to the read side of the TX FIFO: first-word fall-through data, an empty flag, and a read-increment strobe.
- Produces 8N1 framing by default. Stop-bit count and bit period are set by parameters.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per serial bit; legal range 2..65535; counter width is 16 bits.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.
- PARITY_ODD, 0, parity sense when TX_UART_PARITY_EN is defined (0 = even, 1 = odd); ignored otherwise.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  synchronous reset, active-low.
- rdata  in  8  TX FIFO head byte; valid whenever rempty=0.
- rempty  in  1  TX FIFO empty, active high.
- rinc  out  1  TX FIFO read increment, active high; one-cycle registered pulse per byte.
- tx  out  1  serial line; idles high (mark).
- busy  out  1  high from the pop cycle through the last cycle of the final stop bit.

Behaviour:
- Reset: when rst_n=0 at a clk edge, the following apply.
  - state=IDLE, tx=1, rinc=0, busy=0, bit/baud counters=0.
  - Reset mid-frame aborts immediately: tx=1 on the next cycle. The byte already popped is lost and is not re-read.
- All outputs are registered. No combinational path from rdata or rempty to any output.
- States: IDLE, START, DATA, PARITY (present only with TX_UART_PARITY_EN), STOP.
- IDLE: when rempty=0 is sampled at an edge, that same edge does the following.
  - shift register <= rdata, rinc <= 1, tx <= 0, busy <= 1, state <= START, baud counter <= 0.
  - rinc is high for exactly that one following cycle.
  - If rempty=1, stay in IDLE with tx=1.
- START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA: 8 bits, LSB first. Each bit is held CLKS_PER_BIT cycles, and the shift register shifts right at each bit boundary.
  - After bit 7, go to PARITY if it is compiled in; otherwise go to STOP.
- STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles. On the final cycle: state <= IDLE, busy <= 0.
- Back-to-back frames: the FIFO is sampled only in IDLE. The guaranteed minimum gap is one clk of mark between consecutive frames.
  - Frame period = (10 + STOP_BITS - 1 [+1 with parity]) * CLKS_PER_BIT + 1 clk.
- Baud counter: counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary. Bit counter: 0..7.
- rempty is ignored outside IDLE. rdata is captured only on the pop edge, so later FIFO activity cannot corrupt the frame in flight.
- rinc is never asserted while rempty=1. At most one pop occurs per frame.
- FIFO empty→non-empty during STOP: no effect until IDLE is reached.

Optional Feature:
- Macro TX_UART_PARITY_EN.
- When defined:
  - A PARITY state is inserted between DATA and STOP, lasting CLKS_PER_BIT cycles.
  - tx = XOR of the 8 data bits when PARITY_ODD=0, or its inverse when PARITY_ODD=1.
  - Parity is computed from the byte captured at the pop edge.
- When undefined: no PARITY state and no parity logic; the frame goes DATA→STOP directly. PARITY_ODD has no effect.

Test Plan:
- CLKS_PER_BIT=4, STOP_BITS=1. FIFO holds 0xA5 → one rinc pulse, and tx shows 0 then 1,0,1,0,0,1,0,1 then 1, each bit lasting 4 clks (40 clks total). busy falls after the stop bit and rempty goes to 1.
- FIFO holds the mux triplet 0x02, 0x12, 0x34 → exactly 3 rinc pulses, each frame 41 clks apart. Decoded bytes are 0x02, 0x12, 0x34 in order.
- rempty held at 1 for 100 clks after reset → tx=1, rinc=0 and busy=0 throughout.
- rst_n pulled low at clk 15 of a 0xFF frame → tx=1 on the next cycle and state=IDLE. With the FIFO empty, no further rinc occurs and no partial frame resumes.
- STOP_BITS=2, CLKS_PER_BIT=3, byte 0x00 → the stop high lasts 6 clks; frame period is 34 clks back-to-back.
- TX_UART_PARITY_EN defined, PARITY_ODD=0, byte 0x07 → parity bit=1. With PARITY_ODD=1 the parity bit=0, and the frame is 11 bit periods long.
